// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronised rx, 16x oversampling with a 7/8/9 majority vote, runtime frame format,
// frames buffered in a first-word-fall-through FIFO. rx_valid rises the clk after DONE when the FIFO was empty.
// Backpressure: a full FIFO drops the new frame and sets sticky overrun. Optional break detect: UART_RX_BREAK_DET_EN.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int DIV_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic [3:0]             frame_length,
    input  logic                   parity_en,
    input  logic                   parity_type,
    input  logic                   stop2,
    output logic [DATA_W-1:0]      rx_data,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overrun,
    input  logic                   clr_overrun,
    output logic                   break_det
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BRK_WAIT} state_t;
    state_t state, state_nxt;

    logic             rx_s1, rx_s2, rx_d;
    logic             fall, start_det, tick, bit_end, bit_val;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       samp_cnt, bit_idx, cfg_len, len_clamped;
    logic [2:0]       smp;
    logic             cfg_par_en, cfg_par_type, cfg_stop2;
    logic [DATA_W-1:0] data_r;
    logic             par_err_r, frm_err_r, brk_frame;
    logic             push_req, push, pop, full;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall        = rx_d & ~rx_s2;
    assign start_det   = (state == IDLE) && fall;
    assign tick        = (div_cnt == baud_div);
    assign bit_end     = tick && (samp_cnt == 4'd15);
    assign bit_val     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign len_clamped = (frame_length < 4'd5) ? 4'd5 :
                         (frame_length > 4'(DATA_W)) ? 4'(DATA_W) : frame_length;

    // Divider and sample counter realign to the detected start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
            smp      <= '0;
        end else if (start_det) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt >= 4'd7 && samp_cnt <= 4'd9)
                smp <= {smp[1:0], rx_s2};
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (fall) state_nxt = START;
            START:    if (bit_end) state_nxt = bit_val ? IDLE : DATA;
            DATA:     if (bit_end && (bit_idx == cfg_len - 4'd1))
                          state_nxt = cfg_par_en ? PARITY : STOP1;
            PARITY:   if (bit_end) state_nxt = STOP1;
            STOP1:    if (bit_end) state_nxt = cfg_stop2 ? STOP2 : DONE;
            STOP2:    if (bit_end) state_nxt = DONE;
            DONE:     state_nxt = brk_frame ? BRK_WAIT : IDLE;
            BRK_WAIT: if (rx_s2) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_len      <= '0;
            cfg_par_en   <= 1'b0;
            cfg_par_type <= 1'b0;
            cfg_stop2    <= 1'b0;
            data_r       <= '0;
            bit_idx      <= '0;
            par_err_r    <= 1'b0;
            frm_err_r    <= 1'b0;
        end else if (start_det) begin
            cfg_len      <= len_clamped;
            cfg_par_en   <= parity_en;
            cfg_par_type <= parity_type;
            cfg_stop2    <= stop2;
            data_r       <= '0;
            bit_idx      <= '0;
            par_err_r    <= 1'b0;
            frm_err_r    <= 1'b0;
        end else if (bit_end) begin
            case (state)
                DATA: begin
                    data_r  <= data_r | (DATA_W'(bit_val) << bit_idx);
                    bit_idx <= bit_idx + 4'd1;
                end
                PARITY:       par_err_r <= bit_val != (^data_r ^ cfg_par_type);
                STOP1, STOP2: frm_err_r <= frm_err_r | ~bit_val;
                default: ;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit, stop1_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit   <= 1'b0;
            stop1_bit <= 1'b1;
        end else if (start_det) begin
            par_bit   <= 1'b0;
            stop1_bit <= 1'b1;
        end else if (bit_end) begin
            if (state == PARITY) par_bit   <= bit_val;
            if (state == STOP1)  stop1_bit <= bit_val;
        end
    end

    assign brk_frame = (data_r == '0) && !par_bit && !stop1_bit;
    assign break_det = (state == DONE) && brk_frame;
`else
    assign brk_frame = 1'b0;
    assign break_det = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_req   = (state == DONE) && !brk_frame;
    assign rx_valid   = (fifo_count != '0);
    assign full       = (fifo_count == (AW+1)'(DEPTH));
    assign pop        = rx_valid && rx_ready;
    assign push       = push_req && (!full || pop);
    assign head       = mem[rd_ptr];
    assign rx_data    = rx_valid ? head[DATA_W-1:0] : '0;
    assign parity_err = rx_valid & head[DATA_W];
    assign frame_err  = rx_valid & head[DATA_W+1];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {frm_err_r, par_err_r, data_r};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
            if (push_req && !push) overrun <= 1'b1;
            else if (clr_overrun)  overrun <= 1'b0;
        end
    end
endmodule
